// File: rtl/adder_tree_scheduler_pkg.sv
// Shared constants for the adder-tree scheduler slice.
//   OPERAND_W    : width of one operand and of the tree sum
//   NUM_OPERANDS : operands per vector
//   VEC_W        : packed vector width (NUM_OPERANDS * OPERAND_W)
//   TREE_LAT     : adder tree latency, tree_in register to tree_sum
package adder_tree_pkg;

    localparam int unsigned OPERAND_W    = 8;
    localparam int unsigned NUM_OPERANDS = 8;
    localparam int unsigned VEC_W        = OPERAND_W * NUM_OPERANDS;
    localparam int unsigned TREE_LAT     = 3;

    typedef logic [OPERAND_W-1:0] operand_t;
    typedef logic [VEC_W-1:0]     vector_t;

endpackage

// File: rtl/adder_tree_scheduler_rr_arbiter.sv
// Round-robin arbiter.
//   clk, rst_n : clock, async active-low reset (pointer -> 0)
//   req        : per-requester request
//   enable     : arbitration permitted this cycle
//   grant      : one-hot grant, zero when !enable or no request
//   idx        : index of the selected requester (valid when |grant)
// The pointer marks the highest-priority requester and moves to one past
// the winner whenever a grant is issued.
module rr_arbiter
    import adder_tree_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       enable,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] ptr;
    logic            found;
    int unsigned     cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(ptr) + off) % NUM_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = ID_W'(cand);
            end
        end
        if (enable && found) begin
            grant = NUM_REQ'(1) << idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (enable && found) begin
            ptr <= (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
        end
    end

endmodule

// File: rtl/adder_tree_scheduler.sv
// Shares one pipelined 8-input adder tree between NUM_REQ requesters.
//   req_valid/req_data/req_ready : per-requester vector handshake
//   tree_in                      : registered vector to the adder tree
//   tree_sum                     : tree output, TREE_LAT cycles after tree_in
//   res_valid/res_ready/res_sum/res_id : result FIFO head, valid/ready
//   busy                         : work in the tree pipe or FIFO
// Issue is credit-limited: every vector in the tree already owns a FIFO
// slot, so the tree never stalls and the FIFO can never overflow.
module adder_tree_scheduler
    import adder_tree_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TREE_LAT   = adder_tree_pkg::TREE_LAT,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*VEC_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [VEC_W-1:0]           tree_in,
    input  logic [OPERAND_W-1:0]       tree_sum,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OPERAND_W-1:0]       res_sum,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic                       busy
);

    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned PIPE_N = TREE_LAT + 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + PIPE_N + 1);

    logic [PIPE_N-1:0]    pipe_vld;
    logic [ID_W-1:0]      pipe_id  [PIPE_N];
    logic [OPERAND_W-1:0] fifo_sum [FIFO_DEPTH];
    logic [ID_W-1:0]      fifo_id  [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [OCC_W-1:0]     occupancy;
    logic                 issue_en;
    logic                 handshake;
    logic [ID_W-1:0]      grant_idx;
    logic                 push;
    logic                 pop;

    // Occupancy counts queued results plus every vector still in the tree.
    // A pop in the same cycle is deliberately not credited.
    always_comb begin
        occupancy = OCC_W'(count);
        for (int unsigned i = 0; i < PIPE_N; i++) begin
            occupancy = occupancy + OCC_W'(pipe_vld[i]);
        end
    end

    assign issue_en  = occupancy < OCC_W'(FIFO_DEPTH);
    assign handshake = |req_ready;
    assign push      = pipe_vld[PIPE_N-1];
    assign pop       = res_valid && res_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .enable (issue_en),
        .grant  (req_ready),
        .idx    (grant_idx)
    );

    // Issue register and valid/ID pipe tracking the tree latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tree_in  <= '0;
            pipe_vld <= '0;
            for (int unsigned i = 0; i < PIPE_N; i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            tree_in  <= handshake ? req_data[32'(grant_idx) * VEC_W +: VEC_W] : '0;
            pipe_vld <= {pipe_vld[PIPE_N-2:0], handshake};
            pipe_id[0] <= grant_idx;
            for (int unsigned i = 1; i < PIPE_N; i++) begin
                pipe_id[i] <= pipe_id[i-1];
            end
        end
    end

    // Result FIFO; storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_sum[i] <= '0;
                fifo_id[i]  <= '0;
            end
        end else begin
            if (push) begin
                fifo_sum[wr_ptr] <= tree_sum;
                fifo_id[wr_ptr]  <= pipe_id[PIPE_N-1];
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign res_valid = (count != '0);
    assign res_sum   = fifo_sum[rd_ptr];
    assign res_id    = fifo_id[rd_ptr];
    assign busy      = (|pipe_vld) || res_valid;

endmodule

// File: tb/tb_adder_tree_scheduler.sv
module tb_adder_tree_scheduler;

    localparam int NUM_REQ    = 4;
    localparam int TREE_LAT   = 3;
    localparam int FIFO_DEPTH = 8;
    localparam int ID_W       = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ*64-1:0]   req_data = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [63:0]             tree_in;
    logic [7:0]              tree_sum = '0;
    logic                    res_valid;
    logic                    res_ready = 1'b0;
    logic [7:0]              res_sum;
    logic [ID_W-1:0]         res_id;
    logic                    busy;

    adder_tree_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .TREE_LAT   (TREE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tree_in   (tree_in),
        .tree_sum  (tree_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sum8(input logic [63:0] v);
        logic [7:0] s;
        s = '0;
        for (int j = 0; j < 8; j++) s = s + v[8*j +: 8];
        return s;
    endfunction

    // Adder tree stand-in: three registered stages, sum after TREE_LAT edges.
    logic [7:0] t1 = '0, t2 = '0;
    always @(posedge clk) begin
        t1       <= sum8(tree_in);
        t2       <= t1;
        tree_sum <= t2;
    end

    // Reference model: accepted-but-unpopped results in issue order, each
    // tagged with the edge after which it becomes visible at the output.
    typedef struct {
        logic [7:0] sum;
        int         id;
        int         rdy;
    } exp_t;

    exp_t        q[$];
    int          ptr_m = 0;
    int          edge_cnt = 0;
    logic [63:0] exp_tree = '0;
    int          grants[$];
    logic [7:0]  got_sum[$];
    int          got_id[$];
    int          checks = 0;
    int          errors = 0;

    task automatic model_reset();
        q.delete();
        ptr_m    = 0;
        exp_tree = '0;
    endtask

    task automatic tick();
        logic [NUM_REQ-1:0] exp_ready;
        logic [63:0]        gdata;
        int                 g;
        bit                 exp_valid;
        bit                 pp;
        @(negedge clk);
        exp_ready = '0;
        g = -1;
        gdata = '0;
        if (q.size() < FIFO_DEPTH) begin
            for (int o = 0; o < NUM_REQ; o++) begin
                int c;
                c = (ptr_m + o) % NUM_REQ;
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            gdata = req_data[g*64 +: 64];
        end
        checks++;
        if (req_ready !== exp_ready) begin
            errors++;
            $display("FAIL req_ready got %b expected %b at %0t", req_ready, exp_ready, $time);
        end
        exp_valid = (q.size() > 0) && (edge_cnt >= q[0].rdy);
        checks++;
        if (res_valid !== exp_valid) begin
            errors++;
            $display("FAIL res_valid got %b expected %b at %0t", res_valid, exp_valid, $time);
        end
        if (exp_valid) begin
            checks++;
            if (res_sum !== q[0].sum || res_id !== ID_W'(q[0].id)) begin
                errors++;
                $display("FAIL result got sum %h id %0d expected sum %h id %0d at %0t",
                         res_sum, res_id, q[0].sum, q[0].id, $time);
            end
        end
        checks++;
        if (busy !== (q.size() > 0)) begin
            errors++;
            $display("FAIL busy got %b expected %b at %0t", busy, q.size() > 0, $time);
        end
        checks++;
        if (tree_in !== exp_tree) begin
            errors++;
            $display("FAIL tree_in got %h expected %h at %0t", tree_in, exp_tree, $time);
        end
        pp = exp_valid && res_ready;
        if (pp) begin
            got_sum.push_back(res_sum);
            got_id.push_back(int'(res_id));
        end
        @(posedge clk);
        edge_cnt++;
        if (pp) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back('{sum8(gdata), g, edge_cnt + TREE_LAT + 1});
            ptr_m = (g + 1) % NUM_REQ;
            grants.push_back(g);
            exp_tree = gdata;
        end else begin
            exp_tree = '0;
        end
        #1;
    endtask

    task automatic rand_data();
        for (int w = 0; w < NUM_REQ * 2; w++) req_data[32*w +: 32] = $urandom();
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || tree_in !== 64'd0 ||
            res_sum !== 8'd0 || res_id !== '0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%b b=%b t=%h s=%h id=%0d r=%b expected all zero",
                     res_valid, busy, tree_in, res_sum, res_id, req_ready);
        end
        do_reset();
        tick();
    endtask

    task automatic test_single();
        int base;
        base = got_sum.size();
        res_ready = 1'b1;
        for (int j = 0; j < 8; j++) req_data[8*j +: 8] = 8'(j + 1);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (8) tick();
        checks++;
        if (got_sum.size() != base + 1) begin
            errors++;
            $display("FAIL single_count got %0d expected 1", got_sum.size() - base);
        end else if (got_sum[base] !== 8'h24 || got_id[base] != 0) begin
            errors++;
            $display("FAIL single_result got %h/%0d expected 24/0", got_sum[base], got_id[base]);
        end
    endtask

    task automatic test_overflow();
        int base;
        base = got_sum.size();
        req_data[2*64 +: 64] = '1;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (8) tick();
        checks++;
        if (got_sum.size() != base + 1) begin
            errors++;
            $display("FAIL overflow_count got %0d expected 1", got_sum.size() - base);
        end else if (got_sum[base] !== 8'hF8 || got_id[base] != 2) begin
            errors++;
            $display("FAIL overflow_result got %h/%0d expected f8/2", got_sum[base], got_id[base]);
        end
    endtask

    task automatic test_round_robin();
        int gb, rb;
        do_reset();
        res_ready = 1'b1;
        gb = grants.size();
        rb = got_id.size();
        req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            rand_data();
            tick();
        end
        req_valid = '0;
        repeat (8) tick();
        checks++;
        if (grants.size() - gb != 12) begin
            errors++;
            $display("FAIL rr_issue_count got %0d expected 12", grants.size() - gb);
        end
        for (int i = 0; i < 12 && gb + i < grants.size(); i++) begin
            checks++;
            if (grants[gb+i] != i % NUM_REQ) begin
                errors++;
                $display("FAIL rr_order[%0d] got %0d expected %0d", i, grants[gb+i], i % NUM_REQ);
            end
        end
        checks++;
        if (got_id.size() - rb != 12) begin
            errors++;
            $display("FAIL rr_result_count got %0d expected 12", got_id.size() - rb);
        end
        for (int i = 0; i < 12 && rb + i < got_id.size(); i++) begin
            checks++;
            if (got_id[rb+i] != i % NUM_REQ) begin
                errors++;
                $display("FAIL rr_result_id[%0d] got %0d expected %0d", i, got_id[rb+i], i % NUM_REQ);
            end
        end
    endtask

    task automatic test_backpressure();
        int gb, rb;
        do_reset();
        res_ready = 1'b0;
        gb = grants.size();
        req_valid = 4'b0010;
        for (int i = 0; i < 14; i++) begin
            rand_data();
            tick();
        end
        checks++;
        if (grants.size() - gb != FIFO_DEPTH) begin
            errors++;
            $display("FAIL bp_accepts got %0d expected %0d", grants.size() - gb, FIFO_DEPTH);
        end
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL bp_ready got %b expected 0000", req_ready);
        end
        rb = got_id.size();
        gb = grants.size();
        res_ready = 1'b1;
        repeat (20) tick();
        checks++;
        if (got_id.size() - rb < FIFO_DEPTH) begin
            errors++;
            $display("FAIL bp_drain got %0d expected at least %0d", got_id.size() - rb, FIFO_DEPTH);
        end
        checks++;
        if (grants.size() == gb) begin
            errors++;
            $display("FAIL bp_resume got 0 new issues expected more than 0");
        end
    endtask

    // Full occupancy with the consumer toggling, so pushes and pops coincide.
    task automatic test_push_pop_full();
        res_ready = 1'b0;
        req_valid = 4'b1010;
        repeat (12) tick();
        for (int i = 0; i < 24; i++) begin
            res_ready = i[0];
            rand_data();
            tick();
        end
        res_ready = 1'b1;
        req_valid = '0;
        repeat (14) tick();
        checks++;
        if (q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_drain got pending=%0d busy=%b expected 0/0", q.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        res_ready = 1'b0;
        req_valid = 4'b0100;
        repeat (5) begin
            rand_data();
            tick();
        end
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || tree_in !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset got v=%b b=%b t=%h expected 0/0/0", res_valid, busy, tree_in);
        end
        model_reset();
        repeat (2) @(posedge clk);
        req_valid = '1;
        rand_data();
        res_ready = 1'b1;
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (grants.size() == 0 || grants[grants.size()-1] != 0) begin
            errors++;
            $display("FAIL post_reset_grant got %0d expected 0",
                     grants.size() == 0 ? -1 : grants[grants.size()-1]);
        end
        req_valid = '0;
        repeat (8) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req_valid = NUM_REQ'($urandom());
            res_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (16) tick();
        checks++;
        if (q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL random_drain got pending=%0d busy=%b expected 0/0", q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_push_pop_full();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_tree_scheduler.md
Name: adder_tree_scheduler

Overview:
Shares the three-stage pipelined 8-input adder tree between NUM_REQ requesters. Round-robin arbitration grants one 8-operand vector per cycle into a registered issue stage that drives the tree. Requester IDs and valids are tracked alongside the tree's fixed latency. Completed sums go into a credit-protected result FIFO with a valid/ready output.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TREE_LAT, 3, tree latency in cycles, tree input to tree_sum
FIFO_DEPTH, 8, result FIFO entries (>= TREE_LAT+3 for full throughput)
ID_W, derived clog2(NUM_REQ), local only, requester tag width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand vector valid
req_data  in  NUM_REQ*64  per-requester 8x8-bit operands; requester i at [64i+63:64i], operand j at [8j+7:8j] within it
req_ready  out  NUM_REQ  one-hot acceptance, combinational
tree_in  out  64  registered operand vector to the adder tree
tree_sum  in  8  final-stage registered sum from the tree
res_valid  out  1  result available (FIFO not empty)
res_ready  in  1  consumer accepts result
res_sum  out  8  result sum (FIFO head)
res_id  out  ID_W  requester index of the result
busy  out  1  any vector in flight or FIFO not empty

Behaviour:
- Reset (async assert, sync deassert assumed upstream): tree_in=0; valid/ID pipe cleared; FIFO empty; res_valid=0; res_sum=0; res_id=0; busy=0; RR pointer=0 (requester 0 highest priority). In-flight work is discarded.
- Occupancy = FIFO count + number of set bits in the valid pipe. Both are sampled at cycle start.
- Issue is allowed iff occupancy < FIFO_DEPTH and at least one req_valid is high. Same-cycle pops are not credited.
- Grant: the first requesting index at or after the RR pointer, wrapping. req_ready[g]=1 only for the granted index, and only when issue is allowed. All other bits are 0.
- Handshake: req_valid[g] && req_ready[g] at edge k. tree_in <= req_data[g], and the valid/ID pipe stage0 <= {1,g}. The RR pointer becomes (g+1) mod NUM_REQ.
- No handshake: tree_in <= 0, stage0 valid <= 0, pointer holds.
- The valid/ID pipe is 1+TREE_LAT stages and shifts every cycle; the datapath has no stall.
- When the last stage is valid, {tree_sum, id} is pushed at that edge. With handshake at edge k, the push happens at edge k+1+TREE_LAT, and res_valid is high in the following cycle.
- Sum is modular 8-bit; overflow wraps silently with no carry output.
- FIFO: push and pop in the same cycle are both honoured, including when full. Overflow cannot occur by the credit rule. Pop happens when res_valid && res_ready.
- res_sum and res_id show the FIFO head. Both hold their value while res_valid && !res_ready.
- Result order equals issue order across all requesters.
- A requester deasserting req_valid without a handshake is legal and is never granted.

Decomposition:
- Package adder_tree_pkg holds OPERAND_W=8, NUM_OPERANDS=8, VEC_W=64 and TREE_LAT=3.
- One sub-module, rr_arbiter (NUM_REQ; inputs req, enable; outputs one-hot grant and index; pointer update on enable&&|req).
- FIFO and valid/ID pipe stay inline.

Test Plan:
- Single vector: requester 0 sends operands 1..8 with a tree model. Expect req_ready[0] in the same cycle, then res_valid 4 cycles after the handshake edge with res_sum=36 (0x24), res_id=0.
- Overflow: requester 2 sends all operands 0xFF. Expect res_sum=0xF8, res_id=2.
- Round robin: all 4 requesters valid continuously, res_ready=1. Expect grant order 0,1,2,3,0,1 with one issue per cycle and no bubbles. Results arrive in the same ID order.
- Backpressure: res_ready=0, requester 1 continuously valid. Expect exactly 8 accepts, then req_ready=0. Raise res_ready: all 8 drain in order, issue resumes, and the FIFO never overflows.
- Simultaneous push/pop at full: FIFO full, push arriving while res_ready=1. Expect count unchanged and head advanced correctly.
- Reset mid-operation: assert rst_n=0 with 3 in flight and 2 queued. Expect immediate res_valid=0, busy=0 and tree_in=0. After release, no stale results appear and requester 0 is granted first.
